// File: rtl/lattice_addrgen_pkg.sv
// Shared constants and state encoding for the binomial-lattice backward-induction
// address sequencer.
package lattice_addrgen_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_WB_LAT = 6;
    // Bubble lengths never exceed WB_LAT-1, and WB_LAT is at most 15.
    localparam int GAP_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/lattice_addrgen_wb_delay_line.sv
// Fixed-depth {valid, addr} shift line that carries read issues forward to the
// write-back strobe; pending_o flags entries not yet presented at the output.
module lattice_addrgen_wb_delay_line #(
    parameter int DEPTH = 6,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic          pending_o
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    addr_q [DEPTH];

    // NOTE: the whole line, data included, is reset: a stale valid bit would
    // raise wr_en after a mid-sequence reset, and wr_addr must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
            vld_q[0]  <= valid_i;
            addr_q[0] <= addr_i;
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

    // The output stage is excluded so done can land the cycle after the last wr_en.
    always_comb begin
        pending_o = valid_i;
        for (int i = 0; i < DEPTH - 1; i++) pending_o = pending_o | vld_q[i];
    end

endmodule

// File: rtl/lattice_addrgen.sv
// Backward-induction read/write index sequencer for the binomial lattice.
// Define ADDRGEN_STALL_EN to add the stall input that holds read issue.
module lattice_addrgen
    import lattice_addrgen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WB_LAT = DEF_WB_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_steps,
`ifdef ADDRGEN_STALL_EN
    input  logic              stall,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] step,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   j_q, j_d, t_q, t_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, step_q, step_d;
    logic                rd_valid_q, rd_valid_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]   cur_j, cur_t;
    logic                issue, stall_w, pending;

`ifdef ADDRGEN_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // j_q/t_q name the node that the next issue edge will present on rd_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            j_q        <= '0;
            t_q        <= '0;
            gap_q      <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            t_q        <= t_d;
            gap_q      <= gap_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            step_q     <= step_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        t_d        = t_q;
        gap_d      = gap_q;
        rd_valid_d = 1'b0;
        rd_addr_d  = rd_addr_q;
        step_d     = step_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        cur_j      = j_q;
        cur_t      = t_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (num_steps == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cur_j   = '0;
                        cur_t   = num_steps - 1'b1;
                        j_d     = cur_j;
                        t_d     = cur_t;
                        state_d = ST_RUN;
                        issue   = !stall_w;
                    end
                end
            end
            ST_RUN: issue = !stall_w;
            ST_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GAP_W'(1)) state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!pending) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = cur_j;
            step_d     = cur_t;
            if (cur_j == cur_t) begin
                if (cur_t == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    t_d = cur_t - 1'b1;
                    j_d = '0;
                    // A step of L=t+1 nodes needs WB_LAT+1-L bubbles when L <= WB_LAT.
                    if (cur_t >= ADDR_W'(WB_LAT)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(WB_LAT) - GAP_W'(cur_t);
                    end
                end
            end else begin
                j_d = cur_j + 1'b1;
            end
        end
    end

    lattice_addrgen_wb_delay_line #(
        .DEPTH (WB_LAT),
        .AW    (ADDR_W)
    ) u_wb_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (rd_valid_q),
        .addr_i    (rd_addr_q),
        .valid_o   (wr_en),
        .addr_o    (wr_addr),
        .pending_o (pending)
    );

    assign rd_addr  = rd_addr_q;
    assign rd_valid = rd_valid_q;
    assign step     = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lattice_addrgen.sv
// Scoreboard bench for lattice_addrgen: expected read/write events are queued at
// start and popped as the DUT produces rd_valid/wr_en/done.
module tb_lattice_addrgen;
    import lattice_addrgen_pkg::*;

    localparam int AW     = DEF_ADDR_W;
    localparam int WB_LAT = 6;

    typedef struct {
        int cyc;
        int addr;
        int stp;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_steps = '0;
`ifdef ADDRGEN_STALL_EN
    logic          stall = 1'b0;
`endif
    logic [AW-1:0] rd_addr, wr_addr, step;
    logic          rd_valid, wr_en, busy, done;

    lattice_addrgen #(
        .ADDR_W (AW),
        .WB_LAT (WB_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_steps (num_steps),
`ifdef ADDRGEN_STALL_EN
        .stall     (stall),
`endif
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  exp_done = 0;
    int  done_cnt = 0;
    bit  mon_en = 1'b0;
    ev_t rd_q[$];
    ev_t wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected events relative to the start cycle (start sampled at the end of cycle 0).
    // Stall held during cycle c suppresses the read that would appear in cycle c+1.
    function automatic void build(input int n, input int s_lo);
        int c = 1;
        rd_q.delete();
        wr_q.delete();
        if (n == 0) begin
            exp_done = 2;
            return;
        end
        for (int t = n - 1; t >= 0; t--) begin
            for (int j = 0; j <= t; j++) begin
                while (c - 1 >= s_lo && c - 1 < s_lo + 3) c++;
                rd_q.push_back('{c, j, t});
                wr_q.push_back('{c + WB_LAT, j, t});
                c++;
            end
            if (t > 0 && t + 1 <= WB_LAT) c += WB_LAT - t;
        end
        exp_done = (c - 1) + WB_LAT + 1;
    endfunction

    always @(negedge clk) begin : monitor
        int  rel;
        ev_t e;
        if (mon_en) begin
            rel = cyc - t0;
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", rel, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr", rd_addr, e.addr);
                    check("rd_step", step, e.stp);
                    check("rd_cycle", rel, e.cyc);
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", rel, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_cycle", rel, e.cyc);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cycle", rel, exp_done);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run(input int n, input int s_lo);
        int rel;
        build(n, s_lo);
        done_cnt = 0;
        @(negedge clk);
        t0        = cyc;
        mon_en    = 1'b1;
        start     = 1'b1;
        num_steps = AW'(n);
        for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
            @(negedge clk);
            rel   = cyc - t0;
            // A second start during the sequence must be ignored.
            start = (n >= 3 && rel == 4);
`ifdef ADDRGEN_STALL_EN
            stall = (rel >= s_lo && rel < s_lo + 3);
`endif
        end
        start = 1'b0;
`ifdef ADDRGEN_STALL_EN
        stall = 1'b0;
`endif
        repeat (WB_LAT + 4) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("idle_busy", busy, 0);
        mon_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_step"}, step, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int wr_seen;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(1, -100);
        run(3, -100);
        run(20, -100);
        run(0, -100);

        // Reset in the middle of the first step of an N=10 sequence.
        build(10, -100);
        @(negedge clk);
        t0        = cyc;
        start     = 1'b1;
        num_steps = AW'(10);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        wr_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en || rd_valid) wr_seen++;
        end
        check("after_reset_activity", wr_seen, 0);
        run(5, -100);

`ifdef ADDRGEN_STALL_EN
        run(10, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lattice_addrgen.md
# lattice_addrgen

Backward-induction sequencer for the American put binomial lattice. It walks the tree from step N-1 down to step 0 and emits one read node index per cycle to the bank address decoder, which fans it into the four-bank read addresses. It also emits a matching delayed write index/strobe for the compare-and-writeback stage, and inserts hazard bubbles on short steps so in-place updates stay coherent. It sits directly upstream of the address decoder and is the lattice's only source of read addresses.

## Interface
- ADDR_W, 13, node index width; must match the decoder's input address width
- WB_LAT, 6, cycles from a node's read issue to its write being visible to a later read issue; 1..15
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only when idle
- num_steps  in  ADDR_W  N, tree depth, captured at start
- stall  in  1  hold read issue (present only with ADDRGEN_STALL_EN)
- rd_addr  out  ADDR_W  node index j to read (decoder fetches j and j+1)
- rd_valid  out  1  rd_addr valid this cycle
- wr_addr  out  ADDR_W  node index to write back
- wr_en  out  1  write strobe
- step  out  ADDR_W  current step t
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, GAP, DRAIN.
- IDLE + start: capture N. If N==0, go to DRAIN, issue no reads. Otherwise set t=N-1, j=0, go to RUN.
- RUN: issue rd_addr=j, rd_valid=1, then j++. Step length L=t+1 nodes (j=0..t).
  - After j==t issues: if t==0, go to DRAIN.
  - Else if L>WB_LAT, go directly to RUN with t-1, j=0 (no bubble).
  - Else go to GAP for WB_LAT+1-L cycles, then RUN with t-1, j=0.
- GAP: rd_valid=0; counters frozen.
- DRAIN: wait until the write delay line holds no valid entry, then pulse done and go to IDLE.
- Write path: a WB_LAT-deep shift line of {valid, j}. wr_en/wr_addr appear exactly WB_LAT cycles after the matching rd_valid/rd_addr. The line always advances; stall does not affect it.
- start while busy is ignored. Leaf initialisation (nodes 0..N) is done elsewhere. The result is at node 0 after step 0.
- Arithmetic is unsigned ADDR_W. N up to 2^ADDR_W-2, so j+1 never wraps. Larger N is illegal.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- start at cycle 0 gives the first rd_valid at cycle 1; busy rises at cycle 1.
- No-stall cycle count from start to last read: sum over steps of (L + bubble).
- done asserts the cycle after the final wr_en. busy falls with done.
- Reset mid-sequence: asynchronous clear of the state, the counters and the delay line. No wr_en follows.

## Configuration
- ADDRGEN_STALL_EN defined: the stall port exists.
  - While stall=1 in RUN, rd_valid=0 and j/t hold.
  - Stall in GAP still counts down the bubble.
- Undefined: no stall port; issue is never held. Behaviour is otherwise identical.

## Structure
- A shared package holds ADDR_W, the default WB_LAT, and the state encoding enum (IDLE, RUN, GAP, DRAIN).
- One sub-module is natural: wb_delay_line, a parameterised {valid, addr} shift register of depth WB_LAT with an any-valid output used by DRAIN.

## Test plan
- N=1, WB_LAT=6: rd_addr 0 at cycle 1 only; wr_en/wr_addr 0 at cycle 7; done at cycle 8.
- N=3, WB_LAT=6:
  - Reads 0,1,2 at cycles 1-3, then a 4-cycle gap.
  - Reads 0,1 at cycles 8-9, then a 5-cycle gap.
  - Read 0 at cycle 15; last wr_en at cycle 21; done at cycle 22.
- N=20, WB_LAT=6: no gaps for steps with L≥7. Bubbles of 0 at L=7, then 1..5 as L falls 6..2. Every wr_en lags its read by exactly 6 cycles.
- N=0: no rd_valid and no wr_en; done pulses once; busy never reaches 1 longer than the done cycle.
- Reset asserted mid-RUN with N=10: all outputs 0 immediately; no wr_en after release; a new start behaves as from fresh.
- ADDRGEN_STALL_EN, N=10, stall high for 3 cycles mid-step: rd_valid low for 3 cycles, indices resume without skip or repeat; wr stream has a matching 3-cycle hole.
